// File: rtl/lcd_result_sequencer_pkg.sv
// lcd_pkg: shared constants for the LCD result sequencer.
//   - top FSM and per-byte FSM state encodings
//   - HD44780 command bytes and ASCII constants
//   - dd_step(): one double-dabble iteration (add-3 adjust, then shift left)
package lcd_pkg;

    // Top FSM
    localparam logic [2:0] S_PWRUP = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_IDLE  = 3'd2;
    localparam logic [2:0] S_CONV  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    // Per-byte FSM
    localparam logic [1:0] B_SETUP = 2'd0;
    localparam logic [1:0] B_PULSE = 2'd1;
    localparam logic [1:0] B_HOLD  = 2'd2;
    localparam logic [1:0] B_WAIT  = 2'd3;

    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CMD_HOME_L1 = 8'h80;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // {bcd[11:0], bin[7:0]}: adjust each BCD digit >= 5 by +3, then shift left.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[8+4*i +: 4] >= 4'd5)
                t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: serial double-dabble, 8-bit binary -> 3-digit BCD.
//   clk, reset : clock, synchronous active-high reset
//   start      : 1-cycle request; bin is sampled on this edge
//   bin        : value to convert
//   done       : 1-cycle pulse, 8 cycles after start
//   bcd        : {hundreds, tens, units}; stable from done until next start
module bin2bcd_serial
    import lcd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    logic [19:0] sr;
    logic [2:0]  steps;
    logic        run;

    assign bcd = sr[19:8];

    // The first shift happens on the start edge itself, so eight shifts
    // complete with done visible in the eighth cycle counted from start.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr    <= '0;
            steps <= '0;
            run   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr    <= dd_step({12'd0, bin});
                steps <= 3'd7;
                run   <= 1'b1;
            end else if (run) begin
                sr    <= dd_step(sr);
                steps <= steps - 3'd1;
                if (steps == 3'd1) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_result_sequencer.sv
// lcd_result_sequencer: HD44780 init + timed write of an ALU result as decimal ASCII.
//   clk, reset : clock, synchronous active-high reset
//   alu_result : value to display, captured on an accepted load
//   load       : 1-cycle request, accepted only while busy == 0
//   busy       : init or transaction in progress
//   lcd_data, lcd_rs, lcd_en : LCD bus; lcd_rw/lcd_on/lcd_blon are constants
// Optional feature macro: LCD_SIGNED_EN -- two's complement input, sign char
// written after the home command, one extra CONV cycle for the negate.
module lcd_result_sequencer
    import lcd_pkg::*;
#(
    parameter int PWRUP_WAIT_CYC = 2_000_000,
    parameter int EN_PULSE_CYC   = 12,
    parameter int CMD_WAIT_CYC   = 2_000,
    parameter int CLR_WAIT_CYC   = 82_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] alu_result,
    input  logic       load,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       lcd_blon
);

    localparam int M1   = (PWRUP_WAIT_CYC > EN_PULSE_CYC) ? PWRUP_WAIT_CYC : EN_PULSE_CYC;
    localparam int M2   = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    // Counter holds N-1 for an N-cycle phase, so $clog2(max) bits suffice.
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] PWRUP_LD = CW'(PWRUP_WAIT_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(EN_PULSE_CYC - 1);
    localparam logic [CW-1:0] CMD_LD   = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLR_LD   = CW'(CLR_WAIT_CYC - 1);

    localparam logic [2:0] INIT_LAST = 3'd3;
`ifdef LCD_SIGNED_EN
    localparam logic [2:0] WR_LAST   = 3'd4;
`else
    localparam logic [2:0] WR_LAST   = 3'd3;
`endif

    logic [2:0]    state;
    logic [1:0]    bstate;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;

    logic [2:0]    nidx;
    logic [7:0]    nbyte;
    logic          nrs;
    logic          last_byte;

    logic          bcd_start;
    logic [7:0]    bcd_in;
    logic          bcd_done;
    logic [11:0]   bcd;

    assign lcd_rw   = 1'b0;
    assign lcd_on   = 1'b1;
    assign lcd_blon = 1'b1;

`ifdef LCD_SIGNED_EN
    logic [7:0] value;
    logic       conv_first;
    // First CONV cycle forms the magnitude; 8'h80 maps to 128 unsigned.
    assign bcd_start = (state == S_CONV) && conv_first;
    assign bcd_in    = value[7] ? (~value + 8'd1) : value;
`else
    assign bcd_start = (state == S_IDLE) && load;
    assign bcd_in    = alu_result;
`endif

    bin2bcd_serial u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (bcd_start),
        .bin   (bcd_in),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    // Byte to present at the next SETUP: index restarts at 0 when entering
    // INIT or WRITE from another state, else advances.
    always_comb begin
        nidx  = (state == S_INIT || state == S_WRITE) ? idx + 3'd1 : 3'd0;
        nbyte = LCD_CMD_ENTRY;
        nrs   = 1'b0;
        if (state == S_PWRUP || state == S_INIT) begin
            case (nidx)
                3'd0:    nbyte = LCD_CMD_FUNCSET;
                3'd1:    nbyte = LCD_CMD_DISPON;
                3'd2:    nbyte = LCD_CMD_CLEAR;
                default: nbyte = LCD_CMD_ENTRY;
            endcase
        end else begin
            nrs = (nidx != 3'd0);
            case (nidx)
                3'd0:    nbyte = LCD_CMD_HOME_L1;
`ifdef LCD_SIGNED_EN
                3'd1:    nbyte = value[7] ? ASCII_MINUS : ASCII_SPACE;
                3'd2:    nbyte = ASCII_ZERO + {4'd0, bcd[11:8]};
                3'd3:    nbyte = ASCII_ZERO + {4'd0, bcd[7:4]};
`else
                3'd1:    nbyte = ASCII_ZERO + {4'd0, bcd[11:8]};
                3'd2:    nbyte = ASCII_ZERO + {4'd0, bcd[7:4]};
`endif
                default: nbyte = ASCII_ZERO + {4'd0, bcd[3:0]};
            endcase
        end
        last_byte = (state == S_INIT) ? (idx == INIT_LAST) : (idx == WR_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_PWRUP;
            bstate   <= B_SETUP;
            cnt      <= PWRUP_LD;
            idx      <= '0;
            lcd_data <= 8'h00;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            busy     <= 1'b1;
`ifdef LCD_SIGNED_EN
            value      <= '0;
            conv_first <= 1'b0;
`endif
        end else begin
            case (state)
                S_PWRUP: begin
                    if (cnt == '0) begin
                        state    <= S_INIT;
                        bstate   <= B_SETUP;
                        idx      <= nidx;
                        lcd_data <= nbyte;
                        lcd_rs   <= nrs;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (load) begin
                        busy  <= 1'b1;
                        state <= S_CONV;
`ifdef LCD_SIGNED_EN
                        value      <= alu_result;
                        conv_first <= 1'b1;
`endif
                    end
                end
                S_CONV: begin
`ifdef LCD_SIGNED_EN
                    conv_first <= 1'b0;
`endif
                    if (bcd_done) begin
                        state    <= S_WRITE;
                        bstate   <= B_SETUP;
                        idx      <= nidx;
                        lcd_data <= nbyte;
                        lcd_rs   <= nrs;
                    end
                end
                S_INIT, S_WRITE: begin
                    case (bstate)
                        B_SETUP: begin
                            lcd_en <= 1'b1;
                            bstate <= B_PULSE;
                            cnt    <= PULSE_LD;
                        end
                        B_PULSE: begin
                            if (cnt == '0) begin
                                lcd_en <= 1'b0;
                                bstate <= B_HOLD;
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                        B_HOLD: begin
                            bstate <= B_WAIT;
                            cnt    <= (!lcd_rs && lcd_data == LCD_CMD_CLEAR) ? CLR_LD : CMD_LD;
                        end
                        default: begin
                            if (cnt != '0) begin
                                cnt <= cnt - 1'b1;
                            end else if (last_byte) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                bstate   <= B_SETUP;
                                idx      <= nidx;
                                lcd_data <= nbyte;
                                lcd_rs   <= nrs;
                            end
                        end
                    endcase
                end
                default: state <= S_PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_result_sequencer.sv
// Directed bench for lcd_result_sequencer with short timing parameters.
// Expected LCD bytes are queued as stimulus is applied and popped by a
// strobe monitor on every completed E pulse.
module tb_lcd_result_sequencer;

    localparam int PW  = 10;
    localparam int ENP = 2;
    localparam int CMW = 4;
    localparam int CLW = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] alu_result = 8'h00;
    logic       load = 1'b0;
    logic       busy, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_result_sequencer #(
        .PWRUP_WAIT_CYC (PW),
        .EN_PULSE_CYC   (ENP),
        .CMD_WAIT_CYC   (CMW),
        .CLR_WAIT_CYC   (CLW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_result (alu_result),
        .load       (load),
        .busy       (busy),
        .lcd_data   (lcd_data),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_on     (lcd_on),
        .lcd_blon   (lcd_blon)
    );

    typedef struct {
        logic [7:0] d;
        logic       rs;
        int         gap;   // en-low cycles before this strobe, -1 = unchecked
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic rs, input int gap);
        exp_t e;
        e.d = d; e.rs = rs; e.gap = gap;
        sbq.push_back(e);
    endtask

    task automatic push_init();
        push(8'h38, 1'b0, PW + 1);   // PWRUP idle cycles + SETUP
        push(8'h0C, 1'b0, CMW + 2);  // HOLD + wait + SETUP
        push(8'h01, 1'b0, CMW + 2);
        push(8'h06, 1'b0, CLW + 2);  // long wait follows the clear
    endtask

    task automatic push_value(input logic [7:0] v);
        int m;
`ifdef LCD_SIGNED_EN
        logic neg;
        neg = v[7];
        m = neg ? 256 - int'(v) : int'(v);
`else
        m = int'(v);
`endif
        push(8'h80, 1'b0, -1);
`ifdef LCD_SIGNED_EN
        push(neg ? 8'h2D : 8'h20, 1'b1, CMW + 2);
`endif
        push(8'(48 + m / 100), 1'b1, CMW + 2);
        push(8'(48 + (m / 10) % 10), 1'b1, CMW + 2);
        push(8'(48 + m % 10), 1'b1, CMW + 2);
    endtask

    // Strobe monitor
    int         low_cnt = 0;
    int         hi_cnt = 0;
    int         gap_seen = 0;
    int         nstrobe = 0;
    logic [7:0] d_rise = 8'h00;
    logic       rs_rise = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            low_cnt = 0;
            hi_cnt  = 0;
        end else if (lcd_en) begin
            if (hi_cnt == 0) begin
                gap_seen = low_cnt;
                d_rise   = lcd_data;
                rs_rise  = lcd_rs;
            end
            hi_cnt++;
        end else if (hi_cnt != 0) begin
            nstrobe++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_strobe: observed data=%0h rs=%0b expected none", d_rise, rs_rise);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("byte_data", 32'(d_rise), 32'(e.d));
                chk("byte_rs", 32'(rs_rise), 32'(e.rs));
                chk("en_width", 32'(hi_cnt), 32'(ENP));
                chk("data_stable", 32'({lcd_rs, lcd_data}), 32'({rs_rise, d_rise}));
                if (e.gap >= 0) chk("byte_gap", 32'(gap_seen), 32'(e.gap));
            end
            hi_cnt  = 0;
            low_cnt = 1;
        end else begin
            low_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'h0);
        chk("queue_drained", 32'(sbq.size()), 32'h0);
    endtask

    task automatic wait_strobes(input int target, input string tag);
        int n;
        n = 0;
        while (nstrobe < target && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, 32'(nstrobe), 32'(target));
    endtask

    task automatic do_load(input logic [7:0] v);
        alu_result = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        int base;
        int n;

        // Reset state
        tick(); tick(); tick();
        chk("rst_en", 32'(lcd_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_data", 32'(lcd_data), 32'h0);
        chk("rst_rs", 32'(lcd_rs), 32'h0);
        chk("const_pins", 32'({lcd_rw, lcd_on, lcd_blon}), 32'b011);

        // 1: init sequence
        push_init();
        reset = 1'b0;
        wait_idle("init_busy_fall");
        chk("busy_fall_timing", 32'(low_cnt), 32'(1 + CMW));

        // 2: 255, accepted on the very first idle cycle
        push_value(8'hFF);
        do_load(8'hFF);
        chk("busy_after_load", 32'(busy), 32'h1);
        wait_idle("tx_ff_done");

        // 3: 007 then 000 back to back
        push_value(8'h07);
        do_load(8'h07);
        wait_idle("tx_07_done");
        push_value(8'h00);
        do_load(8'h00);
        wait_idle("tx_00_done");

        // 4: load during WRITE is dropped
        base = nstrobe;
        push_value(8'h2A);
        do_load(8'h2A);
        wait_strobes(base + 1, "reach_write");
        do_load(8'h11);
        chk("busy_mid_write", 32'(busy), 32'h1);
        wait_idle("tx_2a_done");
        repeat (30) tick();
        chk("no_extra_tx", 32'(nstrobe), 32'(base + 4));

        // 6: signed-mode values (unsigned build shows 128 / 005)
        push_value(8'h80);
        do_load(8'h80);
        wait_idle("tx_80_done");
        push_value(8'h05);
        do_load(8'h05);
        wait_idle("tx_05_done");

        // 5: reset during PULSE of the second character
        base = nstrobe;
        push_value(8'hFF);
        do_load(8'hFF);
`ifdef LCD_SIGNED_EN
        wait_strobes(base + 3, "reach_char2");
`else
        wait_strobes(base + 2, "reach_char2");
`endif
        n = 0;
        while (lcd_en !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("char2_pulse", 32'(lcd_en), 32'h1);
        reset = 1'b1;
        tick();
        chk("rst_mid_en", 32'(lcd_en), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h1);
        chk("rst_mid_data", 32'({lcd_rs, lcd_data}), 32'h0);
        sbq.delete();
        push_init();
        reset = 1'b0;
        wait_idle("reinit_busy_fall");

        push_value(8'h07);
        do_load(8'h07);
        wait_idle("post_reset_tx");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
